instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of ID: owns the PC, issues instruction-memory reads, buffers returned words in a small
//  in-order queue, and presents one instruction/cycle to ID. Honours ID's redirect (Alt_PC/Request_Alt_PC) and freeze
//  (WANT_FREEZE). Inserts bubbles (Instr=0, a MIPS nop) when no instruction is ready.

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit_queue.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int          QUEUE_DEPTH_DEF = 4;
  localparam int          MAX_OUTST_DEF   = 2;
  localparam int          QPTR_W_DEF      = $clog2(QUEUE_DEPTH_DEF);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit boundary: ID-side redirect/freeze, IMEM request/response, and the instruction handed to ID.
interface instr_fetch_unit_if;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC;
  logic        WANT_FREEZE;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic        IMEM_Valid;
  logic [31:0] IMEM_Data;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;

  modport master (
    input  Alt_PC, Request_Alt_PC, WANT_FREEZE, IMEM_Ready, IMEM_Valid, IMEM_Data,
    output IMEM_Req, IMEM_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT
  );
  modport slave (
    output Alt_PC, Request_Alt_PC, WANT_FREEZE, IMEM_Ready, IMEM_Valid, IMEM_Data,
    input  IMEM_Req, IMEM_Addr, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT
  );
endinterface

// File: rtl/instr_fetch_unit_queue.sv
// In-order fetch queue of {instr, pc}; wrap-around pointers, flush empties it in one cycle.
import instr_fetch_unit_pkg::*;

module fetch_queue #(
  parameter int DEPTH = QUEUE_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge gclk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IMEM issue with outstanding/drop tracking, fetch queue, registered output to ID.
import instr_fetch_unit_pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int          MAX_OUTST   = MAX_OUTST_DEF,
  localparam int         OW          = $clog2(MAX_OUTST + 1),
  localparam int         CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input logic               CLK,
  input logic               RESET,
  instr_fetch_unit_if.master bus
);
  logic [31:0]   pc, resp_pc;
  logic [OW-1:0] outst, drop;
  logic          redirect, req, accept, resp_keep, push, pop, bypass;
  logic [CW-1:0] q_cnt;
  logic          q_empty, q_full;
  fetch_entry_t  q_head;
  logic [31:0]   out_instr, out_pc, out_pc4;

  assign redirect  = bus.Request_Alt_PC;
  assign req       = RESET && !redirect && ((int'(q_cnt) + int'(outst)) < QUEUE_DEPTH)
                     && (int'(outst) < MAX_OUTST);
  assign accept    = req && bus.IMEM_Ready;
  assign resp_keep = bus.IMEM_Valid && (drop == '0) && !redirect;
  assign pop       = !bus.WANT_FREEZE && !q_empty && !redirect;
  assign bypass    = !bus.WANT_FREEZE && q_empty && resp_keep;
  assign push      = resp_keep && !bypass;

  assign bus.IMEM_Req           = req;
  assign bus.IMEM_Addr          = pc;
  assign bus.Instr1_OUT         = out_instr;
  assign bus.Instr_PC_OUT       = out_pc;
  assign bus.Instr_PC_Plus4_OUT = out_pc4;

  // Responses return in issue order and dropped ones precede all live ones, so the PC of the
  // next kept word is a running counter rather than a second queue.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
    end else begin
      outst <= outst + OW'(accept) - OW'(bus.IMEM_Valid);
      if (redirect) begin
        pc      <= bus.Alt_PC & ~32'h3;
        resp_pc <= bus.Alt_PC & ~32'h3;
        drop    <= outst - OW'(bus.IMEM_Valid);
      end else begin
        if (accept)    pc      <= pc + 32'd4;
        if (resp_keep) resp_pc <= resp_pc + 32'd4;
        if (bus.IMEM_Valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .gclk  (CLK),
    .grst_n(RESET),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ('{instr: bus.IMEM_Data, pc: resp_pc}),
    .rdata (q_head),
    .count (q_cnt),
    .empty (q_empty),
    .full  (q_full)
  );

  // A frozen ID keeps its instruction even across a redirect.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_instr <= NOP_INSTR;
      out_pc    <= '0;
      out_pc4   <= '0;
    end else if (!bus.WANT_FREEZE) begin
      if (!redirect && !q_empty) begin
        out_instr <= q_head.instr;
        out_pc    <= q_head.pc;
        out_pc4   <= q_head.pc + 32'd4;
      end else if (!redirect && resp_keep) begin
        out_instr <= bus.IMEM_Data;
        out_pc    <= resp_pc;
        out_pc4   <= resp_pc + 32'd4;
      end else begin
        out_instr <= NOP_INSTR;
        out_pc    <= '0;
        out_pc4   <= '0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET) !(push && q_full && !pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: IMEM responder, transaction-level fetch model, directed scenarios.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if bus();
  instr_fetch_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  typedef struct {logic [31:0] pc; bit drop; int t;} fly_t;

  int n_tests = 0, n_fail = 0, cyc = 0, lat = 1;
  int first_acc = -1, first_vld = -1;
  logic [31:0] first_pc4 = 32'h0;
  fly_t fly[$];
  logic [31:0] bufq[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc = 32'h0040_0000, exp_opc = 32'h0;
  bit exp_vld = 1'b0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a ^ 32'h1234_5670) | 32'h1;
  endfunction

  function automatic bit nonbubble();
    return (bus.Instr1_OUT != 0) || (bus.Instr_PC_OUT != 0) || (bus.Instr_PC_Plus4_OUT != 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Model: every accepted read is in flight until it returns; a redirect marks all in-flight reads
  // dropped and empties the buffer; ID takes one buffered word per unfrozen cycle.
  always @(negedge CLK) begin
    bit redir, frz, ret, acc, exp_req, keep;
    fly_t f;
    cyc++;
    if (!RESET) begin
      fly.delete();
      bufq.delete();
      exp_pc  = 32'h0040_0000;
      exp_vld = 1'b0;
      bus.IMEM_Valid = 1'b0;
      bus.IMEM_Data  = 32'h0;
      chk("rst_instr", bus.Instr1_OUT, 32'h0);
      chk("rst_pc",    bus.Instr_PC_OUT, 32'h0);
      chk("rst_req",   32'(bus.IMEM_Req), 32'h0);
    end else begin
      chk("out_instr", bus.Instr1_OUT,         exp_vld ? mem_word(exp_opc) : 32'h0);
      chk("out_pc",    bus.Instr_PC_OUT,       exp_vld ? exp_opc : 32'h0);
      chk("out_pc4",   bus.Instr_PC_Plus4_OUT, exp_vld ? exp_opc + 32'd4 : 32'h0);
      if (first_vld < 0 && nonbubble()) begin
        first_vld = cyc;
        first_pc4 = bus.Instr_PC_Plus4_OUT;
      end
      redir   = bus.Request_Alt_PC;
      frz     = bus.WANT_FREEZE;
      exp_req = !redir && (bufq.size() + fly.size()) < 4 && fly.size() < 2;
      chk("req", 32'(bus.IMEM_Req), 32'(exp_req));
      ret = (fly.size() > 0) && (cyc >= fly[0].t + lat);
      bus.IMEM_Valid = ret;
      bus.IMEM_Data  = ret ? mem_word(fly[0].pc) : 32'hDEAD_BEEF;
      acc = bus.IMEM_Req && bus.IMEM_Ready;
      if (acc) begin
        chk("addr", bus.IMEM_Addr, exp_pc);
        acc_log.push_back(bus.IMEM_Addr);
        if (first_acc < 0) first_acc = cyc;
      end
      keep = 1'b0;
      if (ret) begin
        f = fly.pop_front();
        keep = !f.drop;
      end
      if (acc) begin
        fly.push_back('{exp_pc, 1'b0, cyc});
        exp_pc += 32'd4;
      end
      if (redir) begin
        foreach (fly[i]) fly[i].drop = 1'b1;
        bufq.delete();
        exp_pc = bus.Alt_PC & ~32'h3;
        if (!frz) exp_vld = 1'b0;
      end else begin
        if (keep) bufq.push_back(f.pc);
        if (!frz) begin
          if (bufq.size() > 0) begin
            exp_vld = 1'b1;
            exp_opc = bufq.pop_front();
          end else exp_vld = 1'b0;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_acc(int n, string name);
    int k = 0;
    while (acc_log.size() < n && k < 40) begin tick(); k++; end
    if (acc_log.size() < n) timeout(name);
  endtask

  task automatic wait_out(string name);
    int k = 0;
    while (!nonbubble() && k < 40) begin tick(); k++; end
    if (!nonbubble()) timeout(name);
  endtask

  initial begin
    int cnt, n0, k;
    bus.Alt_PC = 32'h0;
    bus.Request_Alt_PC = 1'b0;
    bus.WANT_FREEZE = 1'b0;
    bus.IMEM_Ready = 1'b1;
    tick(3);
    chk("d_rst_instr", bus.Instr1_OUT, 32'h0);
    chk("d_rst_req", 32'(bus.IMEM_Req), 32'h0);

    // Streaming from reset
    RESET = 1'b1;
    acc_log.delete();
    wait_acc(3, "t1_wait");
    tick();
    if (acc_log.size() >= 2) begin
      chk("t1_addr0", acc_log[0], 32'h0040_0000);
      chk("t1_addr1", acc_log[1], 32'h0040_0004);
    end
    chk("t1_latency", 32'(first_vld - first_acc), 32'd2);
    chk("t1_first_pc4", first_pc4, 32'h0040_0004);
    tick(3);

    // Freeze fills the queue, release drains it without gaps
    bus.WANT_FREEZE = 1'b1;
    tick(6);
    chk("t2_buffered", 32'(bufq.size()), 32'd4);
    chk("t2_req_off", 32'(bus.IMEM_Req), 32'h0);
    bus.WANT_FREEZE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (nonbubble()) cnt++;
    end
    chk("t2_no_gap", 32'(cnt), 32'd4);

    // Redirect with two reads outstanding
    lat = 3;
    k = 0;
    while (fly.size() != 2 && k < 20) begin tick(); k++; end
    chk("t3_two_outst", 32'(fly.size()), 32'd2);
    bus.Alt_PC = 32'h0040_0100;
    bus.Request_Alt_PC = 1'b1;
    acc_log.delete();
    tick();
    bus.Request_Alt_PC = 1'b0;
    wait_acc(1, "t3_wait_acc");
    if (acc_log.size() >= 1) chk("t3_addr", acc_log[0], 32'h0040_0100);
    wait_out("t3_wait_out");
    chk("t3_first_pc", bus.Instr_PC_OUT, 32'h0040_0100);
    lat = 1;
    tick(4);

    // Redirect while frozen
    bus.WANT_FREEZE = 1'b1;
    tick(2);
    bus.Alt_PC = 32'h0040_0200;
    bus.Request_Alt_PC = 1'b1;
    tick();
    bus.Request_Alt_PC = 1'b0;
    chk("t4_queue_empty", 32'(bufq.size()), 32'd0);
    chk("t4_held", 32'(nonbubble()), 32'd1);
    tick(4);
    bus.WANT_FREEZE = 1'b0;
    tick();
    chk("t4_first_pc", bus.Instr_PC_OUT, 32'h0040_0200);
    tick(3);

    // IMEM stall
    n0 = acc_log.size();
    bus.IMEM_Ready = 1'b0;
    tick(5);
    chk("t5_no_accept", 32'(acc_log.size() - n0), 32'd0);
    chk("t5_bubble_instr", bus.Instr1_OUT, 32'h0);
    chk("t5_bubble_pc", bus.Instr_PC_OUT, 32'h0);
    chk("t5_req_waiting", 32'(bus.IMEM_Req), 32'd1);
    bus.IMEM_Ready = 1'b1;
    tick(4);

    // PC wrap and async reset mid-stream
    bus.Alt_PC = 32'hFFFF_FFFE;
    bus.Request_Alt_PC = 1'b1;
    acc_log.delete();
    tick();
    bus.Request_Alt_PC = 1'b0;
    wait_acc(2, "t6_wait_acc");
    if (acc_log.size() >= 2) begin
      chk("t6_addr_top", acc_log[0], 32'hFFFF_FFFC);
      chk("t6_addr_wrap", acc_log[1], 32'h0000_0000);
    end
    wait_out("t6_wait_out");
    chk("t6_pc_top", bus.Instr_PC_OUT, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", bus.Instr_PC_Plus4_OUT, 32'h0000_0000);
    tick(2);
    #2 RESET = 1'b0;
    #1;
    chk("t6_arst_instr", bus.Instr1_OUT, 32'h0);
    chk("t6_arst_pc", bus.Instr_PC_OUT, 32'h0);
    chk("t6_arst_pc4", bus.Instr_PC_Plus4_OUT, 32'h0);
    chk("t6_arst_req", 32'(bus.IMEM_Req), 32'h0);
    tick(2);
    RESET = 1'b1;
    tick(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
